cpu_bus_scheduler: RTL

//   Generates the CPU clock (PHI2) from sys_clock_i and time-multiplexes the shared

---
 rtl/cpu_bus_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cpu_bus_scheduler.sv
// cpu_bus_scheduler: generates PHI2 from the system clock and time-multiplexes the
// shared memory bus between the 6502 core and a single host requester.
`timescale 1ns/1ps
module cpu_bus_scheduler #(
  parameter int CYCLE_LEN       = 64,
  parameter int HOST_SLOT_START = 4,
  parameter int HOST_SLOT_LEN   = 8
) (
  input  logic                         sys_clock_i,
  input  logic                         reset_n_i,
  input  logic                         cpu_en_i,
  input  logic                         host_req_i,
  output logic                         cpu_clock_o,
  output logic                         cpu_grant_o,
  output logic                         cpu_done_o,
  output logic                         host_grant_o,
  output logic                         host_ack_o,
  output logic [$clog2(CYCLE_LEN)-1:0] phase_o
);

  localparam int PW = $clog2(CYCLE_LEN);
  localparam int CW = $clog2(HOST_SLOT_LEN + 1);

  localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLE_LEN - 1);
  localparam logic [PW-1:0] HALF_PHASE = PW'(CYCLE_LEN / 2);
  // Host FSM commits one clock before the slot so the grant flop rises on the slot start.
  localparam logic [PW-1:0] SLOT_A_PRE = PW'(HOST_SLOT_START - 1);
  localparam logic [PW-1:0] SLOT_B_PRE = PW'(CYCLE_LEN / 2 + HOST_SLOT_START - 1);
  localparam logic [CW-1:0] GRANT_LAST = CW'(HOST_SLOT_LEN - 2);

  typedef enum logic [1:0] {
    H_IDLE,
    H_PEND,
    H_GRANT,
    H_ACK
  } host_state_e;

  logic [PW-1:0] phase_q, phase_d;
  logic          run_q, run_d;
  logic          cpu_clock_q, cpu_clock_d;
  logic          cpu_done_q, cpu_done_d;
  host_state_e   host_state_q, host_state_d;
  logic [CW-1:0] grant_cnt_q, grant_cnt_d;
  logic          host_grant_q, host_grant_d;
  logic          host_ack_q, host_ack_d;
  logic          slot_hit;

  // CPU outputs are computed from next-state values so they line up with phase_o.
  always_comb begin
    phase_d     = phase_q + PW'(1);
    run_d       = run_q;
    if (phase_q == LAST_PHASE) begin
      phase_d = '0;
      run_d   = cpu_en_i;
    end
    cpu_clock_d = run_d && (phase_d >= HALF_PHASE);
    cpu_done_d  = run_d && (phase_d == LAST_PHASE);
  end

  always_comb begin
    host_state_d = host_state_q;
    grant_cnt_d  = grant_cnt_q;
    slot_hit     = (phase_q == SLOT_A_PRE) || ((phase_q == SLOT_B_PRE) && !run_q);
    case (host_state_q)
      H_IDLE: begin
        if (host_req_i) begin
          host_state_d = H_PEND;
        end
      end
      H_PEND: begin
        if (!host_req_i) begin
          host_state_d = H_IDLE;
        end else if (slot_hit) begin
          grant_cnt_d  = '0;
          host_state_d = (HOST_SLOT_LEN == 1) ? H_ACK : H_GRANT;
        end
      end
      H_GRANT: begin
        if (grant_cnt_q == GRANT_LAST) begin
          host_state_d = H_ACK;
        end else begin
          grant_cnt_d = grant_cnt_q + CW'(1);
        end
      end
      H_ACK: begin
        host_state_d = H_IDLE;
      end
      default: begin
        host_state_d = H_IDLE;
      end
    endcase
    host_grant_d = (host_state_d == H_GRANT) || (host_state_d == H_ACK);
    host_ack_d   = (host_state_d == H_ACK);
  end

  always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_q      <= '0;
      run_q        <= 1'b0;
      cpu_clock_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      host_state_q <= H_IDLE;
      grant_cnt_q  <= '0;
      host_grant_q <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      run_q        <= run_d;
      cpu_clock_q  <= cpu_clock_d;
      cpu_done_q   <= cpu_done_d;
      host_state_q <= host_state_d;
      grant_cnt_q  <= grant_cnt_d;
      host_grant_q <= host_grant_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign cpu_clock_o  = cpu_clock_q;
  assign cpu_grant_o  = cpu_clock_q;
  assign cpu_done_o   = cpu_done_q;
  assign host_grant_o = host_grant_q;
  assign host_ack_o   = host_ack_q;
  assign phase_o      = phase_q;

endmodule
